// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl
// Central pipeline controller for the 5-stage core. Produces write enables
// and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
// latches. It sequences data-memory wait freezes, load-use bubbles,
// branch/jump squashes, held instruction fetches and halt.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit, dhit           instruction / data access completes this cycle
//   mem_dREN, mem_dWEN   MEM-stage load / store request
//   ex_memread, ex_rd    EX-stage load flag and destination register
//   id_rs, id_rt         ID-stage source registers
//   id_uses_rt           ID instruction reads rt
//   id_jump              jump decoded in ID
//   mem_branch_taken     branch resolved taken in MEM
//   wb_halt              halt instruction in WB
//   pc_wen, *_wen        PC and latch enables
//   *_flush              latch flush strobes (only meaningful with wen=1)
//   halt_out             sticky halted flag (registered)
//   stall_cnt, flush_cnt saturating perf counters (PERF_CNT_EN only)
//
// Optional feature macro: PERF_CNT_EN adds stall_cnt/flush_cnt.
module pl_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dREN,
  input  logic              mem_dWEN,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              mem_branch_taken,
  input  logic              wb_halt,
  output logic              pc_wen,
  output logic              ifid_wen,
  output logic              idex_wen,
  output logic              exmem_wen,
  output logic              memwb_wen,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              halt_out
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // state | meaning
  // RUN   | normal issue, hazards resolved combinationally
  // DWAIT | frozen on a data-memory wait (same decode as RUN)
  // HALT  | halted, everything frozen until reset
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DWAIT = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0] state, state_nxt;
  logic       ihit_pend, pend_nxt, halt_nxt;
  logic       dstall, fetch_ok, lu, redirect;
  logic       pc_c, ifid_c, idex_c, exmem_c, memwb_c;
  logic       ifidf_c, idexf_c, exmemf_c;

  assign dstall   = (mem_dREN | mem_dWEN) & ~dhit;
  assign fetch_ok = ihit | ihit_pend;
  assign lu       = ex_memread & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  always_comb begin
    pc_c      = 1'b0;
    ifid_c    = 1'b0;
    idex_c    = 1'b0;
    exmem_c   = 1'b0;
    memwb_c   = 1'b0;
    ifidf_c   = 1'b0;
    idexf_c   = 1'b0;
    exmemf_c  = 1'b0;
    redirect  = 1'b0;
    state_nxt = state;
    pend_nxt  = ihit_pend;
    halt_nxt  = halt_out;
    case (state)
      S_RUN, S_DWAIT: begin
        if (wb_halt) begin
          state_nxt = S_HALT;
          halt_nxt  = 1'b1;
        end else if (dstall) begin
          state_nxt = S_DWAIT;
          pend_nxt  = ihit_pend | ihit;
        end else begin
          state_nxt = S_RUN;
          if (mem_branch_taken) begin
            // Redirect outranks a load-use hazard: the bubble would be squashed anyway.
            redirect = 1'b1;
            {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = 5'b11111;
            {ifidf_c, idexf_c, exmemf_c} = 3'b111;
          end else if (lu) begin
            {idex_c, exmem_c, memwb_c} = 3'b111;
            idexf_c = 1'b1;
          end else if (!fetch_ok) begin
            {ifid_c, idex_c, exmem_c, memwb_c} = 4'b1111;
            ifidf_c = 1'b1;
          end else begin
            {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = 5'b11111;
            ifidf_c = id_jump;
          end
          if (pc_c)
            pend_nxt = 1'b0;
          else if (ihit)
            pend_nxt = 1'b1;
        end
      end
      S_HALT: begin
        halt_nxt = 1'b1;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  // Strobes are held low combinationally while reset is asserted.
  assign pc_wen      = pc_c     & nRST;
  assign ifid_wen    = ifid_c   & nRST;
  assign idex_wen    = idex_c   & nRST;
  assign exmem_wen   = exmem_c  & nRST;
  assign memwb_wen   = memwb_c  & nRST;
  assign ifid_flush  = ifidf_c  & nRST;
  assign idex_flush  = idexf_c  & nRST;
  assign exmem_flush = exmemf_c & nRST;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_RUN;
      ihit_pend <= 1'b0;
      halt_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ihit_pend <= pend_nxt;
      halt_out  <= halt_nxt;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != S_HALT) && !pc_c && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pl_hazard_ctrl.md
Name: pl_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core. Generates write-enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It sequences data-memory wait freezes, load-use bubbles, branch/jump squashes, held instruction fetches and halt. Latches load zeros when flush=1 and wen=1; flush is ignored when wen=0.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, perf-counter width (used only under PERF_CNT_EN)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch completes this cycle
dhit  input  1  data access completes this cycle
mem_dREN  input  1  MEM-stage load request
mem_dWEN  input  1  MEM-stage store request
ex_memread  input  1  EX-stage instruction is a load
ex_rd  input  REG_AW  EX-stage destination register
id_rs  input  REG_AW  ID-stage source register rs
id_rt  input  REG_AW  ID-stage source register rt
id_uses_rt  input  1  ID instruction reads rt
id_jump  input  1  jump decoded in ID
mem_branch_taken  input  1  branch resolved taken in MEM
wb_halt  input  1  halt instruction in WB
pc_wen  output  1  PC update enable
ifid_wen, idex_wen, exmem_wen, memwb_wen  output  1 each  latch enables
ifid_flush, idex_flush, exmem_flush  output  1 each  latch flush strobes
halt_out  output  1  sticky halted flag (registered)

Behaviour:
- Clocking: one clock, CLK; asynchronous active-low reset, nRST.
- State: FSM {RUN, DWAIT, HALT}. Registers: ihit_pend, halt_out.
- Reset: state=RUN, ihit_pend=0, halt_out=0. While nRST=0, all enables and flushes are forced to 0.
- Derived terms:
  - dstall = (mem_dREN|mem_dWEN) & !dhit
  - fetch_ok = ihit | ihit_pend
  - lu = ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt))
- Priority in RUN/DWAIT, first match wins; unlisted outputs are 0:
  1. wb_halt: all enables 0; next state HALT; halt_out<=1.
  2. dstall: all enables 0 (full freeze); next state DWAIT; ihit_pend<=ihit_pend|ihit.
  3. mem_branch_taken: pc_wen=1; all four latch wens=1; ifid_flush=idex_flush=exmem_flush=1.
  4. lu: pc_wen=0, ifid_wen=0; idex_wen=1 with idex_flush=1 (bubble); exmem_wen=memwb_wen=1.
  5. !fetch_ok: pc_wen=0; ifid_wen=1 with ifid_flush=1; idex/exmem/memwb wen=1.
  6. else: all enables 1. If id_jump also holds, ifid_flush=1 (squash wrong-path fetch).
- After rules 3–6: next state RUN.
- ihit_pend is cleared on any cycle with pc_wen=1. It is set by ihit on a cycle with pc_wen=0, except in rule 1.
- The DWAIT state differs from RUN only by label. The cycle dhit arrives evaluates rules 3–6 using the held ihit_pend. A 0-cycle wait (dhit same cycle as request) never enters DWAIT.
- HALT: all enables 0; halt_out=1; inputs ignored until reset.
- Reset asserted mid-DWAIT or in HALT returns to RUN with ihit_pend=0 immediately.
- Simultaneous events:
  - mem_branch_taken with lu: redirect wins, no bubble.
  - id_jump with lu: rule 4 wins; the jump re-presents next cycle.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined, adds outputs stall_cnt and flush_cnt (CNT_W each), reset to 0, saturating at all-ones.
  - stall_cnt increments each cycle where state!=HALT and pc_wen=0.
  - flush_cnt increments each cycle rule 3 fires.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Test Plan:
1. Reset: hold nRST=0, drive ihit=1 -> all enables/flushes 0, halt_out=0. Release with ihit=1 -> all enables 1 next cycle.
2. Load-use: ex_memread=1, ex_rd=5, id_rs=5, ihit=1 -> pc_wen=0, ifid_wen=0, idex_flush=1, exmem_wen=1. Repeat with ex_rd=0 -> no stall.
3. Data wait: mem_dREN=1, dhit=0 for 3 cycles, ihit=1 on cycle 1 only -> 3 frozen cycles, state DWAIT. On dhit=1 with ihit=0, all enables 1 (ihit_pend used), then ihit_pend=0.
4. Branch: mem_branch_taken=1 with lu also true -> pc_wen=1, three flushes=1, idex_flush from redirect, no ifid hold.
5. Halt: wb_halt=1 while dstall=1 -> all enables 0, halt_out=1 next cycle and stays 1 across 10 cycles of random inputs. nRST pulse clears it.
6. PERF_CNT_EN: 4 stall cycles + 2 redirects -> stall_cnt=4, flush_cnt=2. Preload near all-ones -> saturates, no wrap.
